// File: rtl/npu_pkg.sv
// Shared NPU defaults and small elaboration-time helpers.
package npu_pkg;

  localparam int unsigned NPU_N          = 4;
  localparam int unsigned NPU_DATA_WIDTH = 8;
  localparam int unsigned NPU_ACC_WIDTH  = 32;

  // Number of live partial sums at tree level lvl when starting from n terms.
  function automatic int unsigned level_count(int unsigned n, int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

endpackage

// File: rtl/adder_tree.sv
// Balanced binary adder tree over N signed ACC_WIDTH terms; wraps modulo 2^ACC_WIDTH.
module adder_tree
  import npu_pkg::*;
#(
  parameter int unsigned N         = NPU_N,
  parameter int unsigned ACC_WIDTH = NPU_ACC_WIDTH
) (
  input  logic [N*ACC_WIDTH-1:0]        terms_i,
  output logic signed [ACC_WIDTH-1:0]   sum_o
);

  localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 0;

  logic signed [ACC_WIDTH-1:0] lvl [LEVELS+1][N];

  always_comb begin
    for (int unsigned l = 0; l <= LEVELS; l++) begin
      for (int unsigned j = 0; j < N; j++) begin
        lvl[l][j] = '0;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      lvl[0][j] = terms_i[j*ACC_WIDTH +: ACC_WIDTH];
    end
    for (int unsigned l = 0; l < LEVELS; l++) begin
      for (int unsigned j = 0; j < N/2; j++) begin
        if (j < level_count(N, l) / 2) begin
          lvl[l+1][j] = lvl[l][2*j] + lvl[l][2*j+1];
        end
      end
      // An unpaired last element is forwarded untouched to the next level.
      if (level_count(N, l) % 2 == 1) begin
        lvl[l+1][level_count(N, l) / 2] = lvl[l][level_count(N, l) - 1];
      end
    end
  end

  assign sum_o = lvl[LEVELS][0];

endmodule

// File: rtl/dot_product.sv
// Signed N-element dot product: combinational result plus a one-cycle registered copy.
module dot_product
  import npu_pkg::*;
#(
  parameter int unsigned N          = NPU_N,
  parameter int unsigned DATA_WIDTH = NPU_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = NPU_ACC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N*DATA_WIDTH-1:0]       x,
  input  logic [N*DATA_WIDTH-1:0]       w,
  input  logic                          in_valid,
  output logic signed [ACC_WIDTH-1:0]   dp,
  output logic signed [ACC_WIDTH-1:0]   dp_q,
  output logic                          out_valid
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]    prod [N];
  logic [N*ACC_WIDTH-1:0]  terms;

  always_comb begin
    terms = '0;
    for (int unsigned i = 0; i < N; i++) begin
      prod[i] = PW'(signed'(x[i*DATA_WIDTH +: DATA_WIDTH]))
              * PW'(signed'(w[i*DATA_WIDTH +: DATA_WIDTH]));
      terms[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(prod[i]);
    end
  end

  adder_tree #(
    .N         (N),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tree (
    .terms_i (terms),
    .sum_o   (dp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dp_q <= dp;
      end
    end
  end

endmodule

// File: tb/tb_dot_product.sv
// Self-checking bench for dot_product: directed cases plus random vectors on N=4, N=1 and N=5 builds.
module tb_dot_product;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid;

  logic [31:0]        x4, w4;
  logic signed [31:0] dp4, dpq4;
  logic               ov4;

  logic [7:0]         x1, w1;
  logic signed [31:0] dp1, dpq1;
  logic               ov1;

  logic [39:0]        x5, w5;
  logic signed [15:0] dp5, dpq5;
  logic               ov5;

  dot_product #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .w(w4), .in_valid(in_valid),
    .dp(dp4), .dp_q(dpq4), .out_valid(ov4)
  );

  dot_product #(.N(1), .DATA_WIDTH(8), .ACC_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .w(w1), .in_valid(in_valid),
    .dp(dp1), .dp_q(dpq1), .out_valid(ov1)
  );

  // Narrow accumulator so five max-magnitude products actually wrap.
  dot_product #(.N(5), .DATA_WIDTH(8), .ACC_WIDTH(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .x(x5), .w(w5), .in_valid(in_valid),
    .dp(dp5), .dp_q(dpq5), .out_valid(ov5)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int xa[5];
  int wa[5];
  longint exp4, exp5;
  logic   expv;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pack(input int a[5]);
    logic [39:0] p;
    for (int i = 0; i < 5; i++) p[i*8 +: 8] = 8'(a[i]);
    return p;
  endfunction

  // Reference: plain integer sum of products, reduced modulo 2^accw as signed.
  function automatic longint model(input int n, input int accw);
    longint s = 0;
    longint m;
    for (int i = 0; i < n; i++) s += longint'(xa[i]) * longint'(wa[i]);
    m = longint'(64'd1) << accw;
    s = s & (m - 1);
    if (s >= (m >>> 1)) s -= m;
    return s;
  endfunction

  task automatic apply(input logic v);
    logic [39:0] px, pw;
    px = pack(xa);
    pw = pack(wa);
    x4 = px[31:0];  w4 = pw[31:0];
    x1 = px[7:0];   w1 = pw[7:0];
    x5 = px;        w5 = pw;
    in_valid = v;
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    apply(v);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    xa = '{1, 2, 3, 4, 0};
    wa = '{5, 6, 7, 8, 0};
    apply(1'b1);
    tick();
    tick();
    chk("reset_dpq", longint'(dpq4), 0);
    chk("reset_ov", longint'(ov4), 0);
    chk("reset_dp_comb", longint'(dp4), 70);

    drive(1'b1);
    rst_n = 1'b1;
    chk("basic_dp", longint'(dp4), 70);
    tick();
    chk("basic_dpq", longint'(dpq4), 70);
    chk("basic_ov", longint'(ov4), 1);

    xa = '{-128, -128, -128, -128, 0};
    wa = '{-128, -128, -128, -128, 0};
    drive(1'b0);
    chk("neg_neg_dp", longint'(dp4), 65536);
    wa = '{127, 127, 127, 127, 0};
    drive(1'b0);
    chk("neg_pos_dp", longint'(dp4), -65024);

    // Back-to-back stream 70, -29, 0 then an idle cycle.
    xa = '{1, 2, 3, 4, 0};      wa = '{5, 6, 7, 8, 0};
    drive(1'b1);
    tick();
    chk("stream0_dpq", longint'(dpq4), 70);
    chk("stream0_ov", longint'(ov4), 1);
    xa = '{3, -2, 0, 7, 0};     wa = '{-4, 5, 9, -1, 0};
    drive(1'b1);
    chk("mixed_dp", longint'(dp4), -29);
    tick();
    chk("stream1_dpq", longint'(dpq4), -29);
    chk("stream1_ov", longint'(ov4), 1);
    xa = '{0, 0, 0, 0, 0};      wa = '{-77, 100, 13, -128, 0};
    drive(1'b1);
    chk("zero_x_dp", longint'(dp4), 0);
    tick();
    chk("stream2_dpq", longint'(dpq4), 0);
    chk("stream2_ov", longint'(ov4), 1);
    xa = '{9, 9, 9, 9, 0};      wa = '{9, 9, 9, 9, 0};
    drive(1'b0);
    tick();
    chk("idle_dpq_hold", longint'(dpq4), 0);
    chk("idle_ov", longint'(ov4), 0);

    // Input changes while idle must not disturb a held nonzero result.
    xa = '{3, -2, 0, 7, 0};     wa = '{-4, 5, 9, -1, 0};
    drive(1'b1);
    tick();
    xa = '{1, 2, 3, 4, 0};      wa = '{5, 6, 7, 8, 0};
    drive(1'b0);
    tick();
    chk("hold_dpq", longint'(dpq4), -29);
    chk("hold_ov", longint'(ov4), 0);

    // Reset mid-stream discards the pair; next valid pair flows normally.
    drive(1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst_dpq", longint'(dpq4), 0);
    chk("midrst_ov", longint'(ov4), 0);
    chk("midrst_dp_comb", longint'(dp4), 70);
    drive(1'b1);
    rst_n = 1'b1;
    tick();
    chk("recover_dpq", longint'(dpq4), 70);
    chk("recover_ov", longint'(ov4), 1);

    // Wrap check on the 16-bit accumulator build: 5 * 16384 = 81920 -> 16384.
    xa = '{-128, -128, -128, -128, -128};
    wa = '{-128, -128, -128, -128, -128};
    drive(1'b0);
    chk("wrap5_dp", longint'(dp5), 16384);

    drive(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp4 = 0;
    exp5 = 0;
    expv = 1'b0;

    for (int k = 0; k < 1000; k++) begin
      logic v;
      for (int i = 0; i < 5; i++) begin
        xa[i] = int'($urandom_range(255)) - 128;
        wa[i] = int'($urandom_range(255)) - 128;
      end
      v = 1'($urandom_range(1));
      drive(v);
      chk("rand_dp4", longint'(dp4), model(4, 32));
      chk("rand_dp1", longint'(dp1), model(1, 32));
      chk("rand_dp5", longint'(dp5), model(5, 16));
      if (v) begin
        exp4 = model(4, 32);
        exp5 = model(5, 16);
      end
      expv = v;
      tick();
      chk("rand_dpq4", longint'(dpq4), exp4);
      chk("rand_ov4", longint'(ov4), longint'(expv));
      chk("rand_dpq5", longint'(dpq5), exp5);
      chk("rand_ov5", longint'(ov5), longint'(expv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
